// File: rtl/seven_segment_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed segment bus, waits for each
// {digit_en, seg} pattern to settle, and recovers the hex nibble shown on each digit.
module seven_segment_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] hex_value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    pattern_err,
    output logic                    select_err,
    output logic [7:0]              err_count
);

    localparam int unsigned SW     = NUM_DIGITS + 7;
    localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);

    logic [SW-1:0]         r_sample;
    logic [7:0]            r_count;
    logic                  r_strobe;
    logic [NUM_DIGITS-1:0] r_seen;

    logic [SW-1:0]         w_in;
    logic                  w_differ;
    logic [7:0]            w_count_d;
    logic                  w_fire;
    logic [NUM_DIGITS-1:0] w_en;
    logic [6:0]            w_seg;
    logic                  w_onehot;
    logic                  w_legal;
    logic [3:0]            w_nibble;
    logic [NUM_DIGITS-1:0] w_seen_set;

    assign w_in     = {digit_en, seg};
    assign w_differ = (w_in != r_sample);

    // Stability counter next state: restart on change, saturate at the threshold.
    always_comb begin
        if (w_differ) begin
            w_count_d = 8'd1;
        end else if (r_count == STABLE) begin
            w_count_d = r_count;
        end else begin
            w_count_d = r_count + 8'd1;
        end
    end

    // Fire only on the edge where the count first lands on the threshold.
    assign w_fire = (w_count_d == STABLE) && (w_differ || (r_count != STABLE));

    // Sample register, stability count and the registered capture strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= '0;
            r_count  <= 8'd0;
            r_strobe <= 1'b0;
        end else begin
            if (w_differ) begin
                r_sample <= w_in;
            end
            r_count  <= w_count_d;
            r_strobe <= w_fire;
        end
    end

    assign w_en       = r_sample[SW-1:7];
    assign w_seg      = r_sample[6:0];
    assign w_onehot   = (w_en != '0) && ((w_en & (w_en - 1'b1)) == '0);
    assign w_seen_set = r_seen | w_en;

    // Segment pattern to nibble decode of the settled sample.
    always_comb begin
        w_legal  = 1'b1;
        w_nibble = 4'h0;
        case (w_seg)
            7'h3F: w_nibble = 4'h0;
            7'h06: w_nibble = 4'h1;
            7'h5B: w_nibble = 4'h2;
            7'h4F: w_nibble = 4'h3;
            7'h66: w_nibble = 4'h4;
            7'h6D: w_nibble = 4'h5;
            7'h7D: w_nibble = 4'h6;
            7'h07: w_nibble = 4'h7;
            7'h7F: w_nibble = 4'h8;
            7'h6F: w_nibble = 4'h9;
            7'h77: w_nibble = 4'hA;
            7'h7C: w_nibble = 4'hB;
            7'h39: w_nibble = 4'hC;
            7'h5E: w_nibble = 4'hD;
            7'h79: w_nibble = 4'hE;
            7'h71: w_nibble = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    // Capture action: update the selected digit and status; clear overrides status only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_value   <= '0;
            digit_valid <= '0;
            r_seen      <= '0;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
            select_err  <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (r_strobe && w_onehot && w_legal) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_en[i]) begin
                        hex_value[4*i +: 4] <= w_nibble;
                    end
                end
            end
            if (clear) begin
                digit_valid <= '0;
                r_seen      <= '0;
                pattern_err <= 1'b0;
                select_err  <= 1'b0;
                err_count   <= 8'd0;
            end else if (r_strobe) begin
                if (!w_onehot) begin
                    select_err <= 1'b1;
                end else if (w_legal) begin
                    digit_valid <= digit_valid | w_en;
                    if (w_seen_set == '1) begin
                        r_seen     <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        r_seen <= w_seen_set;
                    end
                end else begin
                    digit_valid <= digit_valid & ~w_en;
                    pattern_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule
